// File: rtl/dispatch_buffer.sv
// rtl/dispatch_buffer.sv - in-order dispatch FIFO with operand wakeup snooping
module dispatch_buffer #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4,
  parameter int FUC_BITS     = 2,
  parameter int DEPTH        = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_inst_valid,
  output logic                                   in_inst_ready,
  input  logic [INST_ID_BITS-1:0]                in_inst_id,
  input  logic [31:0]                            in_raw_instr,
  input  logic [63:0]                            in_instr_pc,
  input  logic [FUC_BITS-1:0]                    in_fu_choice,
  input  logic [MAX_OPERANDS-1:0]                in_prn_input_valid,
  input  logic [MAX_OPERANDS-1:0]                in_prn_input_ready,
  input  logic [MAX_OPERANDS-1:0]                in_prn_output_valid,
  input  logic [MAX_OPERANDS*PRN_BITS-1:0]       in_prn_input,
  input  logic [MAX_OPERANDS*PRN_BITS-1:0]       in_prn_output,
  input  logic [FU_COUNT*MAX_OPERANDS-1:0]       set_prn_ready,
  input  logic [FU_COUNT*MAX_OPERANDS*PRN_BITS-1:0] set_prn,
  input  logic [FU_COUNT-1:0]                    queue_ready,
  output logic                                   out_inst_valid,
  output logic [INST_ID_BITS-1:0]                out_inst_id,
  output logic [31:0]                            out_raw_instr,
  output logic [63:0]                            out_instr_pc,
  output logic [FUC_BITS-1:0]                    out_fu_choice,
  output logic [MAX_OPERANDS-1:0]                out_prn_input_valid,
  output logic [MAX_OPERANDS-1:0]                out_prn_input_ready,
  output logic [MAX_OPERANDS-1:0]                out_prn_output_valid,
  output logic [MAX_OPERANDS*PRN_BITS-1:0]       out_prn_input,
  output logic [MAX_OPERANDS*PRN_BITS-1:0]       out_prn_output,
  input  logic                                   flush,
  output logic [$clog2(DEPTH):0]                 occupancy
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int OPW = MAX_OPERANDS * PRN_BITS;
  localparam int NB  = FU_COUNT * MAX_OPERANDS;

  logic [INST_ID_BITS-1:0] id_q   [DEPTH];
  logic [INST_ID_BITS-1:0] id_d   [DEPTH];
  logic [31:0]             raw_q  [DEPTH];
  logic [31:0]             raw_d  [DEPTH];
  logic [63:0]             pc_q   [DEPTH];
  logic [63:0]             pc_d   [DEPTH];
  logic [FUC_BITS-1:0]     fuc_q  [DEPTH];
  logic [FUC_BITS-1:0]     fuc_d  [DEPTH];
  logic [MAX_OPERANDS-1:0] piv_q  [DEPTH];
  logic [MAX_OPERANDS-1:0] piv_d  [DEPTH];
  logic [MAX_OPERANDS-1:0] rdy_q  [DEPTH];
  logic [MAX_OPERANDS-1:0] rdy_d  [DEPTH];
  logic [MAX_OPERANDS-1:0] pov_q  [DEPTH];
  logic [MAX_OPERANDS-1:0] pov_d  [DEPTH];
  logic [OPW-1:0]          pin_q  [DEPTH];
  logic [OPW-1:0]          pin_d  [DEPTH];
  logic [OPW-1:0]          pout_q [DEPTH];
  logic [OPW-1:0]          pout_d [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic                head_qr;
  logic [FUC_BITS-1:0] head_fuc;
  logic                push, pop;

  // True when any writeback lane broadcasts the given PRN this cycle
  function automatic logic bcast_match(input logic [PRN_BITS-1:0] prn,
                                       input logic [NB-1:0] vld,
                                       input logic [NB*PRN_BITS-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (vld[b] && (tags[b*PRN_BITS +: PRN_BITS] == prn)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Handshake: head dispatchability via its FU queue; out-of-range FU choices never match
  always_comb begin
    head_fuc = fuc_q[head_q];
    head_qr  = 1'b0;
    for (int f = 0; f < FU_COUNT; f++) begin
      if (int'(head_fuc) == f) head_qr = queue_ready[f];
    end
    in_inst_ready  = (count_q < CW'(DEPTH)) && !flush;
    out_inst_valid = (count_q != '0) && head_qr && !flush;
    push           = in_inst_valid && in_inst_ready;
    pop            = out_inst_valid;
    occupancy      = count_q;
  end

  // Head payload, zeroed when not dispatching; ready merges same-cycle wakeups
  always_comb begin
    out_inst_id          = '0;
    out_raw_instr        = '0;
    out_instr_pc         = '0;
    out_fu_choice        = '0;
    out_prn_input_valid  = '0;
    out_prn_input_ready  = '0;
    out_prn_output_valid = '0;
    out_prn_input        = '0;
    out_prn_output       = '0;
    if (out_inst_valid) begin
      out_inst_id          = id_q[head_q];
      out_raw_instr        = raw_q[head_q];
      out_instr_pc         = pc_q[head_q];
      out_fu_choice        = fuc_q[head_q];
      out_prn_input_valid  = piv_q[head_q];
      out_prn_output_valid = pov_q[head_q];
      out_prn_input        = pin_q[head_q];
      out_prn_output       = pout_q[head_q];
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        out_prn_input_ready[j] = piv_q[head_q][j] &&
          (rdy_q[head_q][j] ||
           bcast_match(pin_q[head_q][j*PRN_BITS +: PRN_BITS], set_prn_ready, set_prn));
      end
    end
  end

  // Next state: snoop wakeups, then flush or enqueue/dequeue with pointer wrap
  always_comb begin
    id_d    = id_q;
    raw_d   = raw_q;
    pc_d    = pc_q;
    fuc_d   = fuc_q;
    piv_d   = piv_q;
    rdy_d   = rdy_q;
    pov_d   = pov_q;
    pin_d   = pin_q;
    pout_d  = pout_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    for (int e = 0; e < DEPTH; e++) begin
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        if (piv_q[e][j] &&
            bcast_match(pin_q[e][j*PRN_BITS +: PRN_BITS], set_prn_ready, set_prn)) begin
          rdy_d[e][j] = 1'b1;
        end
      end
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int e = 0; e < DEPTH; e++) rdy_d[e] = '0;
    end else begin
      if (push) begin
        id_d[tail_q]   = in_inst_id;
        raw_d[tail_q]  = in_raw_instr;
        pc_d[tail_q]   = in_instr_pc;
        fuc_d[tail_q]  = in_fu_choice;
        piv_d[tail_q]  = in_prn_input_valid;
        pov_d[tail_q]  = in_prn_output_valid;
        pin_d[tail_q]  = in_prn_input;
        pout_d[tail_q] = in_prn_output;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
          rdy_d[tail_q][j] = in_prn_input_valid[j] &&
            (in_prn_input_ready[j] ||
             bcast_match(in_prn_input[j*PRN_BITS +: PRN_BITS], set_prn_ready, set_prn));
        end
        tail_d = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        id_q[e]   <= '0;
        raw_q[e]  <= '0;
        pc_q[e]   <= '0;
        fuc_q[e]  <= '0;
        piv_q[e]  <= '0;
        rdy_q[e]  <= '0;
        pov_q[e]  <= '0;
        pin_q[e]  <= '0;
        pout_q[e] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int e = 0; e < DEPTH; e++) begin
        id_q[e]   <= id_d[e];
        raw_q[e]  <= raw_d[e];
        pc_q[e]   <= pc_d[e];
        fuc_q[e]  <= fuc_d[e];
        piv_q[e]  <= piv_d[e];
        rdy_q[e]  <= rdy_d[e];
        pov_q[e]  <= pov_d[e];
        pin_q[e]  <= pin_d[e];
        pout_q[e] <= pout_d[e];
      end
    end
  end

endmodule

// File: doc/dispatch_buffer.md
DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 SHALL take parameters: INST_ID_BITS, default 6, instruction ID width.
REQ-002 SHALL take parameters: PRN_BITS, default 6, physical register number width.
REQ-003 SHALL take parameters: MAX_OPERANDS, default 3, operand slots per instruction.
REQ-004 SHALL take parameters: FU_COUNT, default 4, number of FU/queues downstream.
REQ-005 SHALL take parameters: FUC_BITS, default 2, FU choice width.
REQ-006 SHALL take parameters: DEPTH, default 4, entry count, power of two, at least 2.
REQ-007 SHALL have ports: clk, input, 1, single clock, rising edge.
REQ-008 SHALL have ports: rst, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports: in_inst_valid, input, 1, upstream rename offers an instruction.
REQ-010 SHALL have ports: in_inst_ready, output, 1, buffer accepts this cycle.
REQ-011 SHALL have ports: in_inst_id, in_raw_instr, in_instr_pc, in_fu_choice, inputs, INST_ID_BITS/32/64/FUC_BITS, instruction payload.
REQ-012 SHALL have ports: in_prn_input_valid, in_prn_input_ready, in_prn_output_valid, inputs, 1 x MAX_OPERANDS, operand flags.
REQ-013 SHALL have ports: in_prn_input, in_prn_output, inputs, PRN_BITS x MAX_OPERANDS, operand PRNs.
REQ-014 SHALL have ports: set_prn_ready, input, 1 x FU_COUNT x MAX_OPERANDS, writeback broadcast valid.
REQ-015 SHALL have ports: set_prn, input, PRN_BITS x FU_COUNT x MAX_OPERANDS, writeback broadcast PRN.
REQ-016 SHALL have ports: queue_ready, input, 1 x FU_COUNT, per-FU queue has space.
REQ-017 SHALL have ports: out_inst_valid, output, 1, dispatch to router this cycle.
REQ-018 SHALL have ports: out_* payload and operand outputs, mirror of in_* widths.
REQ-019 SHALL have ports: flush, input, 1, synchronous discard of all entries.
REQ-020 SHALL have ports: occupancy, output, $clog2(DEPTH)+1, current entry count.

Function
REQ-021 SHALL be an in-order circular FIFO with head/tail pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0, plus a count register.
REQ-022 SHALL drive in_inst_ready = (count < DEPTH) && !flush, independent of same-cycle dispatch (no full-pop bypass).
REQ-023 SHALL enqueue at tail on the clk edge when in_inst_valid && in_inst_ready, with count +1.
REQ-024 SHALL drive out_inst_valid = (count != 0) && queue_ready[head.fu_choice] && !flush, combinationally from the head entry.
REQ-025 SHALL dequeue head on the clk edge when out_inst_valid = 1; the router consumes unconditionally, with count -1.
REQ-026 SHALL keep count unchanged on simultaneous enqueue and dequeue, with both pointers advancing.
REQ-027 SHALL drive out_* payload from the head entry when out_inst_valid = 1, and all zeros otherwise.
REQ-028 SHALL, each cycle, set a stored operand ready bit for every valid entry operand j with prn_input_valid when any set_prn_ready[f][k] = 1 with set_prn[f][k] == stored PRN.
REQ-029 SHALL drive out_prn_input_ready[j] = stored bit OR same-cycle broadcast match, so a wakeup in the dispatch cycle is not lost.
REQ-030 SHALL apply the broadcast to the incoming instruction on enqueue, stored ready = in_prn_input_ready[j] OR same-cycle match.
REQ-031 SHALL never clear a set ready bit while the entry is resident.
REQ-032 SHALL treat operands with prn_input_valid = 0 as don't-care, with ready stored as 0 and no snoop.
REQ-033 SHALL, on flush = 1, return to empty state at the next edge, ignoring same-cycle enqueue; out_inst_valid and in_inst_ready SHALL be 0 during flush.
REQ-034 SHALL leave the head blocked (out_inst_valid = 0) while its FU queue_ready = 0, with no bypass of younger entries.
REQ-035 SHALL treat in_fu_choice >= FU_COUNT as never dispatchable; it SHALL block until flush.
REQ-036 SHALL drive occupancy = count.

Reset
REQ-037 SHALL, while rst = 0, asynchronously clear head, tail, count, and all entry ready bits; outputs SHALL be out_inst_valid = 0, out_* = 0, occupancy = 0, in_inst_ready = 1.
REQ-038 SHALL discard in-flight entries on reset mid-operation; first enqueue after release lands at index 0.

Verification
REQ-039 SHALL verify fill/full: enqueue 4 with queue_ready all 0 -> occupancy 4, in_inst_ready 0; fifth offer not accepted.
REQ-040 SHALL verify order/wrap: enqueue IDs 1..6 with FU0 ready and interleaved dispatch -> out IDs 1..6 in order across pointer wrap.
REQ-041 SHALL verify HOL blocking: head fu_choice 2, queue_ready = 4'b1011 -> no dispatch; raise queue_ready[2] -> head dispatched same cycle.
REQ-042 SHALL verify wakeup: resident entry prn_input[0] = 17 not ready; set_prn[3][1] = 17 with ready -> out_prn_input_ready[0] = 1 same cycle and after.
REQ-043 SHALL verify enqueue-cycle wakeup and simultaneous push/pop at count 2 -> stored ready 1, count stays 2.
REQ-044 SHALL verify flush with count 3 plus concurrent offer -> occupancy 0 next cycle and offer dropped; rst low mid-stream -> immediate empty state.
